// File: rtl/pdp11_mem_pkg.sv
// Shared encodings for the memory access sequencer: EA selects, read destinations,
// error codes and FSM states.
package pdp11_mem_pkg;

    localparam logic [2:0] SEL_SRC   = 3'd0;
    localparam logic [2:0] SEL_SRC_X = 3'd1;
    localparam logic [2:0] SEL_DST   = 3'd2;
    localparam logic [2:0] SEL_DST_Y = 3'd3;
    localparam logic [2:0] SEL_X     = 3'd4;
    localparam logic [2:0] SEL_Y     = 3'd5;
    localparam logic [2:0] SEL_Z     = 3'd6;

    localparam logic [1:0] DEST_NONE = 2'd0;
    localparam logic [1:0] DEST_X    = 2'd1;
    localparam logic [1:0] DEST_Y    = 2'd2;
    localparam logic [1:0] DEST_IR   = 2'd3;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ODD     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

endpackage

// File: rtl/ea_mux.sv
// Effective-address mux: src, src+X, dst, dst+Y, X, Y, Z.
// Purely combinational; additions wrap modulo 2^WIDTH.
module ea_mux
    import pdp11_mem_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       i_sel,
    input  logic [WIDTH-1:0] i_src,
    input  logic [WIDTH-1:0] i_dst,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [WIDTH-1:0] i_z,
    output logic [WIDTH-1:0] o_ea
);

    always_comb begin
        o_ea = i_z;
        case (i_sel)
            SEL_SRC:   o_ea = i_src;
            SEL_SRC_X: o_ea = i_src + i_x;
            SEL_DST:   o_ea = i_dst;
            SEL_DST_Y: o_ea = i_dst + i_y;
            SEL_X:     o_ea = i_x;
            SEL_Y:     o_ea = i_y;
            SEL_Z:     o_ea = i_z;
            default:   o_ea = i_z;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle memory access sequencer with X/Y/Z/IR holding registers.
// Latency: done two cycles after start with zero wait states; waits on mem_ack up to TIMEOUT cycles.
module mem_access_unit
    import pdp11_mem_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int TIMEOUT       = 15,
    parameter int SIGN_EXT_BYTE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       addr_sel,
    input  logic             write,
    input  logic             byte_acc,
    input  logic [1:0]       dest,
    input  logic             z_we,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] dst,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] ir,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_byte,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack
);

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_wait;
    logic [WIDTH-1:0] r_x, r_y, r_z, r_ir, r_rdata;
    logic [WIDTH-1:0] r_mem_addr, r_mem_wdata;
    logic             r_mem_we, r_mem_byte;
    logic [1:0]       r_dest;
    logic             r_done, r_err;
    logic [1:0]       r_err_code;

    logic [WIDTH-1:0] w_ea;
    logic [WIDTH-1:0] w_wfill;
    logic [7:0]       w_hi_lane;
    logic [7:0]       w_lane;
    logic [WIDTH-1:0] w_rd_ext;
    logic [WIDTH-1:0] w_rd_data;
    logic             w_accept, w_odd, w_ack, w_timeout;

    ea_mux #(.WIDTH(WIDTH)) u_ea_mux (
        .i_sel (addr_sel),
        .i_src (src),
        .i_dst (dst),
        .i_x   (r_x),
        .i_y   (r_y),
        .i_z   (r_z),
        .o_ea  (w_ea)
    );

    // A start landing on the done/err cycle is taken, so only REQ blocks acceptance.
    assign w_accept  = start && (r_state != ST_REQ);
    assign w_odd     = !byte_acc && w_ea[0];
    assign w_ack     = (r_state == ST_REQ) && mem_ack;
    assign w_timeout = (r_state == ST_REQ) && !mem_ack && (r_wait == CNT_LAST);

    always_comb begin
        w_wfill = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_wfill[i] = wdata[i % 8];
        end
    end

    generate
        if (WIDTH >= 16) begin : g_hi_lane
            assign w_hi_lane = mem_rdata[15:8];
        end else begin : g_one_lane
            assign w_hi_lane = mem_rdata[7:0];
        end
    endgenerate

    assign w_lane    = r_mem_addr[0] ? w_hi_lane : mem_rdata[7:0];
    assign w_rd_ext  = (SIGN_EXT_BYTE != 0) ? WIDTH'($signed(w_lane)) : WIDTH'(w_lane);
    assign w_rd_data = r_mem_byte ? w_rd_ext : mem_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_ERR: begin
                if (!w_accept)  w_next = ST_IDLE;
                else if (w_odd) w_next = ST_ERR;
                else            w_next = ST_REQ;
            end
            ST_REQ: begin
                if (mem_ack || w_timeout) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req = (r_state == ST_REQ);
        busy    = (r_state != ST_IDLE) || r_done || r_err;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait <= '0;
        end else if (w_accept) begin
            r_wait <= '0;
        end else if (r_state == ST_REQ && !mem_ack) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_ir        <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_byte  <= 1'b0;
            r_dest      <= DEST_NONE;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_done <= w_ack;
            r_err  <= w_timeout || (w_accept && w_odd);
            if (w_accept) begin
                r_mem_addr  <= w_ea;
                r_mem_we    <= write;
                r_mem_byte  <= byte_acc;
                r_mem_wdata <= byte_acc ? w_wfill : wdata;
                r_dest      <= dest;
                r_err_code  <= w_odd ? ERR_ODD : ERR_NONE;
                if (z_we) r_z <= w_ea;
            end
            if (w_timeout) r_err_code <= ERR_TIMEOUT;
            if (w_ack && !r_mem_we) begin
                r_rdata <= w_rd_data;
                case (r_dest)
                    DEST_X:  r_x  <= w_rd_data;
                    DEST_Y:  r_y  <= w_rd_data;
                    DEST_IR: r_ir <= w_rd_data;
                    default: ;
                endcase
            end
        end
    end

    assign done      = r_done;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign rdata     = r_rdata;
    assign x         = r_x;
    assign y         = r_y;
    assign z         = r_z;
    assign ir        = r_ir;
    assign mem_we    = r_mem_we;
    assign mem_byte  = r_mem_byte;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised bench for mem_access_unit against a transaction-level model of
// the access rules; a zero-extending instance shares all stimulus.
module tb_mem_access_unit;

    localparam int W  = 16;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0, write = 1'b0, byte_acc = 1'b0, z_we = 1'b0, mem_ack = 1'b0;
    logic [2:0]    addr_sel = '0;
    logic [1:0]    dest = '0;
    logic [W-1:0]  src = '0, dst = '0, wdata = '0, mem_rdata = '0;

    logic          busy, done, err, mem_req, mem_we, mem_byte;
    logic [1:0]    err_code;
    logic [W-1:0]  rdata, x, y, z, ir, mem_addr, mem_wdata;

    logic          busy0, done0, err0, mem_req0, mem_we0, mem_byte0;
    logic [1:0]    err_code0;
    logic [W-1:0]  rdata0, x0, y0, z0, ir0, mem_addr0, mem_wdata0;

    mem_access_unit #(.WIDTH(W), .TIMEOUT(TO), .SIGN_EXT_BYTE(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .addr_sel(addr_sel), .write(write),
        .byte_acc(byte_acc), .dest(dest), .z_we(z_we), .src(src), .dst(dst), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .rdata(rdata),
        .x(x), .y(y), .z(z), .ir(ir), .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    mem_access_unit #(.WIDTH(W), .TIMEOUT(TO), .SIGN_EXT_BYTE(0)) u_dut_zx (
        .clk(clk), .reset_n(reset_n), .start(start), .addr_sel(addr_sel), .write(write),
        .byte_acc(byte_acc), .dest(dest), .z_we(z_we), .src(src), .dst(dst), .wdata(wdata),
        .busy(busy0), .done(done0), .err(err0), .err_code(err_code0), .rdata(rdata0),
        .x(x0), .y(y0), .z(z0), .ir(ir0), .mem_req(mem_req0), .mem_we(mem_we0), .mem_byte(mem_byte0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Architectural state as the access rules define it; *_zx tracks the zero-extending copy.
    logic [W-1:0] mx, my, mz, mir, mrd, mir_zx, mrd_zx;
    logic [1:0]   mcode;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_ea(input logic [2:0] sel, input logic [W-1:0] s,
                                           input logic [W-1:0] d);
        case (sel)
            3'd0:    return s;
            3'd1:    return s + mx;
            3'd2:    return d;
            3'd3:    return d + my;
            3'd4:    return mx;
            3'd5:    return my;
            default: return mz;
        endcase
    endfunction

    task automatic model_reset();
        mx = '0; my = '0; mz = '0; mir = '0; mrd = '0; mir_zx = '0; mrd_zx = '0; mcode = 2'd0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".x"}, x, mx);
        chk({tag, ".y"}, y, my);
        chk({tag, ".z"}, z, mz);
        chk({tag, ".ir"}, ir, mir);
        chk({tag, ".rdata"}, rdata, mrd);
        chk({tag, ".rdata_zx"}, rdata0, mrd_zx);
        chk({tag, ".ir_zx"}, ir0, mir_zx);
    endtask

    // Issues one access at the current negedge; returns at the sample where done/err shows.
    // wt = req cycles before ack (>= TO means never ack).
    task automatic do_access(input logic [2:0] sel, input logic wr, input logic byt,
                             input logic [1:0] dsel, input logic zwe, input logic [W-1:0] s,
                             input logic [W-1:0] d, input logic [W-1:0] wd, input int wt,
                             input logic [W-1:0] rd);
        logic [W-1:0] ea, exp_wd, data, data_zx;
        logic [7:0]   lane;
        bit           odd, tmo, stable_ok;
        int           reqs, guard;
        ea     = ref_ea(sel, s, d);
        odd    = !byt && ea[0];
        tmo    = !odd && (wt >= TO);
        exp_wd = byt ? {wd[7:0], wd[7:0]} : wd;
        start = 1'b1; addr_sel = sel; write = wr; byte_acc = byt; dest = dsel; z_we = zwe;
        src = s; dst = d; wdata = wd; mem_ack = 1'b0;
        @(negedge clk);
        start = 1'b0; addr_sel = 3'($urandom); write = 1'($urandom); byte_acc = 1'($urandom);
        z_we = 1'($urandom); src = W'($urandom); dst = W'($urandom); wdata = W'($urandom);
        chk("mem_addr", mem_addr, ea);
        chk("mem_we", mem_we, wr);
        chk("mem_byte", mem_byte, byt);
        chk("mem_wdata", mem_wdata, exp_wd);
        if (zwe) mz = ea;
        reqs = 0; guard = 0; stable_ok = 1'b1;
        while (mem_req === 1'b1 && guard < 64) begin
            if (mem_addr !== ea || mem_wdata !== exp_wd || mem_we !== wr || mem_byte !== byt ||
                busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) stable_ok = 1'b0;
            if (reqs == wt) begin
                mem_ack = 1'b1; mem_rdata = rd;
            end else begin
                mem_ack = 1'b0; mem_rdata = W'($urandom);
            end
            src = W'($urandom); dst = W'($urandom); wdata = W'($urandom);
            reqs++; guard++;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        chk("req_stable", 32'(stable_ok), 32'd1);
        chk("req_cycles", reqs, odd ? 0 : (tmo ? TO : wt + 1));
        mcode = odd ? 2'd1 : (tmo ? 2'd2 : 2'd0);
        if (!odd && !tmo && !wr) begin
            lane    = ea[0] ? rd[15:8] : rd[7:0];
            data    = byt ? {{8{lane[7]}}, lane} : rd;
            data_zx = byt ? {8'h00, lane} : rd;
            mrd = data; mrd_zx = data_zx;
            case (dsel)
                2'd1: mx = data;
                2'd2: my = data;
                2'd3: begin mir = data; mir_zx = data_zx; end
                default: ;
            endcase
        end
        chk("done", done, !odd && !tmo);
        chk("err", err, odd || tmo);
        chk("err_code", err_code, mcode);
        chk("busy_end", busy, 1);
        chk("done_zx", done0, !odd && !tmo);
        check_regs("acc");
    endtask

    // One idle cycle with an optional stray ack that must be ignored.
    task automatic idle_cycle(input logic stray);
        start = 1'b0; mem_ack = stray; mem_rdata = W'($urandom);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle.done", done, 0);
        chk("idle.err", err, 0);
        chk("idle.busy", busy, 0);
        chk("idle.mem_req", mem_req, 0);
        chk("idle.x", x, mx);
        chk("idle.rdata", rdata, mrd);
    endtask

    initial begin
        logic [2:0]   sel;
        logic [1:0]   dsel;
        logic         wr, byt;
        logic [W-1:0] rd;
        int           wt, r;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.err", err, 0);
        chk("rst.err_code", err_code, 0);
        chk("rst.mem_req", mem_req, 0);
        chk("rst.mem_addr", mem_addr, 0);
        check_regs("rst");
        reset_n = 1'b1;
        idle_cycle(1'b1);

        // word read, no wait
        do_access(3'd0, 0, 0, 2'd1, 0, 16'h1000, 16'h0, 16'h0, 0, 16'h1234);
        idle_cycle(1'b0);
        chk("t1.x", x, 16'h1234);
        // byte read, odd lane via dst+Y
        do_access(3'd0, 0, 0, 2'd2, 0, 16'h2000, 16'h0, 16'h0, 1, 16'h0001);
        idle_cycle(1'b0);
        do_access(3'd3, 0, 1, 2'd3, 0, 16'h0, 16'h0200, 16'h0, 0, 16'h8A00);
        chk("t2.mem_addr", mem_addr, 16'h0201);
        chk("t2.rdata", rdata, 16'hFF8A);
        chk("t2.rdata_zx", rdata0, 16'h008A);
        idle_cycle(1'b0);
        // word write, 3 wait states
        do_access(3'd0, 0, 0, 2'd1, 0, 16'h3000, 16'h0, 16'h0, 0, 16'h0400);
        idle_cycle(1'b0);
        do_access(3'd4, 1, 0, 2'd0, 0, 16'h5A5A, 16'hA5A5, 16'hBEEF, 3, 16'h7777);
        chk("t3.mem_wdata", mem_wdata, 16'hBEEF);
        idle_cycle(1'b0);
        // odd word access with Z capture
        do_access(3'd0, 0, 0, 2'd0, 1, 16'h0101, 16'h0, 16'h0, 0, 16'h0);
        chk("t4.z", z, 16'h0101);
        chk("t4.err_code", err_code, 2'd1);
        idle_cycle(1'b0);
        // timeout, then a late ack
        do_access(3'd2, 0, 0, 2'd1, 0, 16'h0, 16'h0800, 16'h0, 1000, 16'h0);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 16'h5555;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("t5.done", done, 0);
        chk("t5.err", err, 0);
        chk("t5.err_code_held", err_code, 2'd2);
        check_regs("t5");
        // wrap: 0xFFFF + 2
        do_access(3'd0, 0, 0, 2'd1, 0, 16'h4000, 16'h0, 16'h0, 0, 16'h0002);
        idle_cycle(1'b0);
        do_access(3'd1, 0, 1, 2'd0, 0, 16'hFFFF, 16'h0, 16'h0, 2, 16'h1234);
        chk("t6.mem_addr", mem_addr, 16'h0001);
        idle_cycle(1'b0);

        for (int i = 0; i < 300; i++) begin
            sel  = 3'($urandom);
            wr   = 1'($urandom);
            byt  = 1'($urandom);
            dsel = 2'($urandom);
            r    = $urandom_range(0, 9);
            case (r)
                6:       wt = TO - 1;
                7:       wt = TO;
                8:       wt = 1000;
                9:       wt = $urandom_range(6, 12);
                default: wt = r;
            endcase
            rd = W'($urandom);
            // keep X/Y identical across both instances so their EAs stay in step
            if (byt && (dsel == 2'd1 || dsel == 2'd2)) begin
                rd[15] = 1'b0; rd[7] = 1'b0;
            end
            do_access(sel, wr, byt, dsel, 1'($urandom), W'($urandom), W'($urandom), W'($urandom), wt, rd);
            if ($urandom_range(0, 2) != 0) idle_cycle(1'($urandom));
        end

        // reset in the middle of a REQ phase
        idle_cycle(1'b0);
        start = 1'b1; addr_sel = 3'd0; write = 1'b0; byte_acc = 1'b0; dest = 2'd1; z_we = 1'b1;
        src = 16'h0040;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rr.mem_req_before", mem_req, 1);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("rr.mem_req", mem_req, 0);
        chk("rr.busy", busy, 0);
        chk("rr.mem_addr", mem_addr, 0);
        check_regs("rr");
        @(negedge clk);
        reset_n = 1'b1;
        idle_cycle(1'b1);
        chk("rr.err_code", err_code, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
